mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: width of the address bus.
REQ-002 SHALL have parameter DATA_W, default 16: width of the data bus.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of cycles to wait for a RAM acknowledge (used only with the timeout feature).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 I_execute  in  1  access request from the control unit; sampled only while O_mem_ready=1.
REQ-008 I_we  in  1  1=write, 0=read; latched when a request is accepted.
REQ-009 I_addr  in  ADDR_W  access address; latched when a request is accepted.
REQ-010 I_wdata  in  DATA_W  write data; latched when a request is accepted.
REQ-011 O_mem_ready  out  1  1=idle and able to accept a request.
REQ-012 O_data_ready  out  1  one-cycle pulse marking completion of an access (read or write).
REQ-013 O_data  out  DATA_W  last read data; held between reads.
REQ-014 O_error  out  1  one-cycle pulse, coincident with O_data_ready, flagging an aborted access.
REQ-015 O_ram_req  out  1  request strobe to RAM; held high until acknowledged.
REQ-016 O_ram_we, O_ram_addr, O_ram_wdata  out  1/ADDR_W/DATA_W  latched copies of I_we, I_addr, I_wdata; stable while O_ram_req=1.
REQ-017 I_ram_ack  in  1  RAM acknowledge; completes the access.
REQ-018 I_ram_rdata  in  DATA_W  read data; valid in the same cycle as I_ram_ack.

Function
REQ-019 SHALL implement a state machine with states IDLE, REQ and DONE.
REQ-020 IDLE: O_mem_ready=1 and O_ram_req=0; if I_execute=1, latch I_we, I_addr and I_wdata and go to REQ.
REQ-021 REQ: O_mem_ready=0 and O_ram_req=1; if I_ram_ack=1 at the clock edge, go to DONE and, for a read, load O_data from I_ram_rdata.
REQ-022 DONE: O_data_ready=1 and O_ram_req=0 for exactly one cycle, then go to IDLE.
REQ-023 Minimum latency: with I_ram_ack already high, a request accepted at edge N gives O_data_ready high after edge N+1 and O_mem_ready high again after edge N+2.
REQ-024 SHALL ignore I_execute outside IDLE; no request is queued.
REQ-025 SHALL ignore I_ram_ack outside REQ.
REQ-026 Writes SHALL leave O_data unchanged.
REQ-027 O_ram_addr, O_ram_we and O_ram_wdata SHALL change only when a request is accepted.

Reset
REQ-028 Reset SHALL force: state=IDLE, O_mem_ready=1, O_ram_req=0, O_data_ready=0, O_error=0, O_data=0, latched address/data/we=0, timeout counter=0.
REQ-029 Reset in any state, including REQ, SHALL abort the access on that edge with no O_data_ready pulse; a late I_ram_ack is then ignored.

Configuration
REQ-030 Macro MEM_CTRL_TIMEOUT_EN defined: count the cycles spent in REQ; if the count reaches TIMEOUT_CYCLES with no I_ram_ack, go to DONE with O_error=1 and O_data unchanged.
REQ-031 MEM_CTRL_TIMEOUT_EN defined: the counter SHALL clear on entry to REQ; an I_ram_ack in the same cycle as the count reaching the limit SHALL win (normal completion, O_error=0).
REQ-032 MEM_CTRL_TIMEOUT_EN undefined: REQ waits indefinitely, O_error is constant 0, and no counter logic is present.

Structure
REQ-033 State encodings and the default widths SHALL live in a shared header alongside the ALU op definitions, so that the control unit can include them.
REQ-034 The timeout counter SHALL be a sub-module named mem_timeout, instantiated only when MEM_CTRL_TIMEOUT_EN is defined.

Verification
REQ-035 Read with I_ram_ack held high, I_addr=0x0010, I_ram_rdata=0xBEEF -> O_ram_req high for 1 cycle, O_data_ready pulse 1 cycle later with O_data=0xBEEF, O_mem_ready back high the next cycle.
REQ-036 Write to I_addr=0x0020 with I_wdata=0x1234, I_ram_ack delayed 5 cycles -> O_ram_addr=0x0020 and O_ram_wdata=0x1234 stable for 5 cycles, then one O_data_ready pulse, O_data unchanged.
REQ-037 I_execute pulsed while in REQ with I_addr=0x0FFF -> ignored; O_ram_addr stays at the original value and exactly one completion occurs.
REQ-038 Reset asserted on the third cycle of REQ, then I_ram_ack=1 -> IDLE after the reset edge, no O_data_ready pulse, the ack is ignored.
REQ-039 MEM_CTRL_TIMEOUT_EN defined with TIMEOUT_CYCLES=4 and I_ram_ack held low -> after 4 REQ cycles, O_data_ready and O_error pulse together; O_data keeps its previous read value.
REQ-040 MEM_CTRL_TIMEOUT_EN defined with I_ram_ack arriving on the limit cycle -> normal completion with O_error=0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, memory FSM states and ALU op codes
// Included by the memory controller and the control unit.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W         = 16;
  localparam int MEM_DATA_W         = 16;
  localparam int MEM_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - control-unit and RAM handshake signals of the memory controller
// slave = controller side, master = control unit / RAM side.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic              I_execute;
  logic              I_we;
  logic [ADDR_W-1:0] I_addr;
  logic [DATA_W-1:0] I_wdata;
  logic              O_mem_ready;
  logic              O_data_ready;
  logic [DATA_W-1:0] O_data;
  logic              O_error;
  logic              O_ram_req;
  logic              O_ram_we;
  logic [ADDR_W-1:0] O_ram_addr;
  logic [DATA_W-1:0] O_ram_wdata;
  logic              I_ram_ack;
  logic [DATA_W-1:0] I_ram_rdata;

  modport slave (
    input  I_execute, I_we, I_addr, I_wdata, I_ram_ack, I_ram_rdata,
    output O_mem_ready, O_data_ready, O_data, O_error,
    output O_ram_req, O_ram_we, O_ram_addr, O_ram_wdata
  );

  modport master (
    output I_execute, I_we, I_addr, I_wdata, I_ram_ack, I_ram_rdata,
    input  O_mem_ready, O_data_ready, O_data, O_error,
    input  O_ram_req, O_ram_we, O_ram_addr, O_ram_wdata
  );

endinterface

// File: rtl/mem_timeout.sv
// rtl/mem_timeout.sv - counts cycles of an unanswered RAM request (built under MEM_CTRL_TIMEOUT_EN)
// o_expire is high in the last allowed REQ cycle; the counter clears when a request is accepted.
module mem_timeout
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  assign o_expire = i_count && (r_count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count && !o_expire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - memory access controller: IDLE/REQ/DONE handshake between control unit and RAM
// Optional RAM-acknowledge timeout enabled by `define MEM_CTRL_TIMEOUT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES
) (
  input logic       clk,
  input logic       reset,
  mem_ctrl_if.slave bus
);

  mem_state_e        r_state;
  mem_state_e        w_next_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;
  logic              w_ack;
  logic              w_in_req;
  logic              w_timeout;
  logic              w_mem_ready;
  logic              w_ram_req;
  logic              w_data_ready;
  logic              w_error;

  assign w_in_req = (r_state == ST_REQ);
  assign w_accept = (r_state == ST_IDLE) && bus.I_execute;
  assign w_ack    = w_in_req && bus.I_ram_ack;

`ifdef MEM_CTRL_TIMEOUT_EN
  logic r_err;

  mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_count  (w_in_req),
    .o_expire (w_timeout)
  );

  // An acknowledge on the limit cycle is a normal completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_in_req) begin
      r_err <= !bus.I_ram_ack && w_timeout;
    end
  end
`else
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.I_execute) w_next_state = ST_REQ;
      ST_REQ:  if (bus.I_ram_ack || w_timeout) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_ready  = 1'b0;
    w_ram_req    = 1'b0;
    w_data_ready = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      ST_IDLE: w_mem_ready = 1'b1;
      ST_REQ:  w_ram_req   = 1'b1;
      ST_DONE: begin
        w_data_ready = 1'b1;
`ifdef MEM_CTRL_TIMEOUT_EN
        w_error      = r_err;
`endif
      end
      default: ;
    endcase
  end

  // RAM-side copies only move on acceptance; read data only on an acknowledged read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.I_we;
        r_addr  <= bus.I_addr;
        r_wdata <= bus.I_wdata;
      end
      if (w_ack && !r_we) begin
        r_data <= bus.I_ram_rdata;
      end
    end
  end

  assign bus.O_mem_ready  = w_mem_ready;
  assign bus.O_ram_req    = w_ram_req;
  assign bus.O_data_ready = w_data_ready;
  assign bus.O_error      = w_error;
  assign bus.O_data       = r_data;
  assign bus.O_ram_we     = r_we;
  assign bus.O_ram_addr   = r_addr;
  assign bus.O_ram_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a RAM responder and a memory reference model
// Timeout cases are exercised when MEM_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif
  localparam int WR_DELAY    = (TO_CYC > 5) ? 5 : TO_CYC - 1;
  localparam int MODE_AUTO   = 0;
  localparam int MODE_HOLD   = 1;
  localparam int MODE_NONE   = 2;
  localparam int MODE_MANUAL = 3;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } done_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_ctrl #(
    .ADDR_W(16),
    .DATA_W(16),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  req_t  req_q[$];
  done_t done_q[$];

  logic [15:0] tb_ram [int unsigned];
  logic [15:0] shadow [int unsigned];
  logic [15:0] model_data = 16'h0;

  int ack_mode   = MODE_NONE;
  bit rand_delay = 1'b0;
  int ram_delay  = 0;
  int wait_cnt   = 0;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ram_read(input logic [15:0] a);
    if (tb_ram.exists(int'(a))) return tb_ram[int'(a)];
    return init_word(a);
  endfunction

  function automatic logic [15:0] shadow_read(input logic [15:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!bus.O_mem_ready && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("mem_ready_budget", bus.O_mem_ready, 1);
  endtask

  task automatic wait_done(output int req_cycles);
    int guard = 0;
    req_cycles = 0;
    while (!bus.O_data_ready && guard < 100) begin
      if (bus.O_ram_req) req_cycles++;
      step();
      guard++;
    end
    check("done_within_budget", bus.O_data_ready, 1);
  endtask

  // Reference model: reads return the last write to that address; writes and aborts keep O_data.
  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d, input logic exp_err);
    wait_idle();
    bus.I_execute = 1'b1;
    bus.I_we      = we;
    bus.I_addr    = a;
    bus.I_wdata   = d;
    req_q.push_back('{we: we, addr: a, wdata: d});
    if (!exp_err) begin
      if (we) shadow[int'(a)] = d;
      else    model_data = shadow_read(a);
    end
    done_q.push_back('{data: model_data, err: exp_err});
    step();
    bus.I_execute = 1'b0;
  endtask

  task automatic junk_pulse();
    bus.I_execute = 1'b1;
    bus.I_we      = 1'($urandom_range(0, 1));
    bus.I_addr    = 16'h0FFF;
    bus.I_wdata   = 16'($urandom);
    step();
    bus.I_execute = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!reset && bus.O_ram_req && bus.I_ram_ack && bus.O_ram_we)
      tb_ram[int'(bus.O_ram_addr)] = bus.O_ram_wdata;
  end

  always @(posedge clk) begin
    #2;
    bus.I_ram_rdata = ram_read(bus.O_ram_addr);
    if (ack_mode == MODE_HOLD) begin
      bus.I_ram_ack = 1'b1;
    end else if (ack_mode == MODE_NONE) begin
      bus.I_ram_ack = 1'b0;
    end else if (ack_mode == MODE_AUTO) begin
      if (bus.O_ram_req) begin
        if (wait_cnt == 0 && rand_delay) ram_delay = $urandom_range(0, 3);
        bus.I_ram_ack = (wait_cnt == ram_delay);
        wait_cnt++;
      end else begin
        bus.I_ram_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.O_ram_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_ram_req", req_q.size(), 1);
        end else begin
          check("ram_addr", bus.O_ram_addr, req_q[0].addr);
          check("ram_we", bus.O_ram_we, req_q[0].we);
          check("ram_wdata", bus.O_ram_wdata, req_q[0].wdata);
        end
      end
      if (bus.O_data_ready) begin
        if (done_q.size() == 0) begin
          check("extra_completion", done_q.size(), 1);
        end else begin
          done_t d;
          d = done_q.pop_front();
          if (req_q.size() != 0) void'(req_q.pop_front());
          check("o_data", bus.O_data, d.data);
          check("o_error", bus.O_error, d.err);
          check("ram_req_in_done", bus.O_ram_req, 0);
        end
      end else if (bus.O_error) begin
        check("error_without_done", bus.O_data_ready, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    bus.I_execute   = 1'b0;
    bus.I_we        = 1'b0;
    bus.I_addr      = 16'h0;
    bus.I_wdata     = 16'h0;
    bus.I_ram_ack   = 1'b0;
    bus.I_ram_rdata = 16'h0;

    reset = 1'b1;
    repeat (3) step();
    check("rst_mem_ready", bus.O_mem_ready, 1);
    check("rst_ram_req", bus.O_ram_req, 0);
    check("rst_data_ready", bus.O_data_ready, 0);
    check("rst_error", bus.O_error, 0);
    check("rst_data", bus.O_data, 0);
    check("rst_ram_addr", bus.O_ram_addr, 0);
    check("rst_ram_we", bus.O_ram_we, 0);
    check("rst_ram_wdata", bus.O_ram_wdata, 0);
    reset = 1'b0;

    // Minimum-latency read with acknowledge held high.
    ack_mode = MODE_HOLD;
    issue(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    wait_done(n);
    issue(1'b0, 16'h0010, 16'h0000, 1'b0);
    check("lat_req_after_accept", bus.O_ram_req, 1);
    step();
    check("lat_data_ready", bus.O_data_ready, 1);
    check("lat_data_beef", bus.O_data, 16'hBEEF);
    check("lat_req_dropped", bus.O_ram_req, 0);
    check("lat_busy_in_done", bus.O_mem_ready, 0);
    step();
    check("lat_ready_again", bus.O_mem_ready, 1);
    check("lat_pulse_one_cycle", bus.O_data_ready, 0);

    // Write with a delayed acknowledge.
    ack_mode   = MODE_AUTO;
    rand_delay = 1'b0;
    ram_delay  = WR_DELAY;
    issue(1'b1, 16'h0020, 16'h1234, 1'b0);
    wait_done(n);
    check("wr_req_cycles", n, WR_DELAY + 1);
    check("wr_ram_addr", bus.O_ram_addr, 16'h0020);
    check("wr_ram_wdata", bus.O_ram_wdata, 16'h1234);
    check("wr_data_kept", bus.O_data, 16'hBEEF);

    // Execute while busy is ignored.
    ram_delay = 2;
    issue(1'b0, 16'h0011, 16'h0000, 1'b0);
    junk_pulse();
    wait_done(n);
    check("busy_exec_ram_addr", bus.O_ram_addr, 16'h0011);
    repeat (3) step();
    check("busy_exec_no_extra", bus.O_mem_ready, 1);

    // Reset on the third REQ cycle, followed by a late acknowledge.
    ack_mode = MODE_MANUAL;
    bus.I_ram_ack = 1'b0;
    issue(1'b0, 16'h0003, 16'h0000, 1'b0);
    step();
    step();
    check("rst_req_still_req", bus.O_ram_req, 1);
    reset = 1'b1;
    bus.I_ram_ack = 1'b1;
    step();
    reset = 1'b0;
    req_q.delete();
    done_q.delete();
    model_data = 16'h0;
    check("abort_idle", bus.O_mem_ready, 1);
    check("abort_no_done", bus.O_data_ready, 0);
    check("abort_ram_req", bus.O_ram_req, 0);
    check("abort_data_cleared", bus.O_data, 0);
    repeat (3) begin
      step();
      check("late_ack_ignored", bus.O_data_ready, 0);
    end
    bus.I_ram_ack = 1'b0;

    // Randomized traffic over a small address window to hit read-after-write.
    ack_mode   = MODE_AUTO;
    rand_delay = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic        we_r;
      logic [15:0] a_r;
      logic [15:0] d_r;
      we_r = 1'($urandom_range(0, 1));
      a_r  = 16'($urandom_range(0, 7));
      d_r  = 16'($urandom);
      issue(we_r, a_r, d_r, 1'b0);
      if ($urandom_range(0, 3) == 0) junk_pulse();
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle();

`ifdef MEM_CTRL_TIMEOUT_EN
    ack_mode = MODE_NONE;
    issue(1'b0, 16'h0005, 16'h0000, 1'b1);
    wait_done(n);
    check("to_req_cycles", n, TO_CYC);
    check("to_error", bus.O_error, 1);

    ack_mode = MODE_MANUAL;
    bus.I_ram_ack = 1'b0;
    issue(1'b0, 16'h0006, 16'h0000, 1'b0);
    repeat (TO_CYC - 1) step();
    bus.I_ram_ack = 1'b1;
    step();
    bus.I_ram_ack = 1'b0;
    check("to_ack_wins_done", bus.O_data_ready, 1);
    check("to_ack_wins_error", bus.O_error, 0);
`endif

    repeat (5) step();
    check("queues_drained", req_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
